// File: rtl/cosine_ci_ctrl.sv
// Nios II multicycle custom-instruction front end for a pipelined CORDIC cosine core.
// Optional macro COSINE_ZERO_SHORTCUT_EN: +/-0 angles return 1.0 without running the core.
`timescale 1ns/1ps

module cosine_ci_ctrl #(
    parameter int CORE_LATENCY = 2,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        core_clk_en,
    output logic [31:0] core_angle,
    input  logic [31:0] core_result
);

    localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    if (CORE_LATENCY < 1 || (2 ** CNT_W) <= CORE_LATENCY) begin : g_param_check
        $error("cosine_ci_ctrl: CNT_W too narrow for CORE_LATENCY");
    end

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_result;
    logic [31:0]       r_core_angle;

    logic              w_start;
    logic              w_shortcut;
    logic              w_last;

    assign w_start = clk_en & start & (r_state == S_IDLE);

`ifdef COSINE_ZERO_SHORTCUT_EN
    assign w_shortcut = (dataa[30:0] == 31'd0);
`else
    assign w_shortcut = 1'b0;
`endif

    // r_cnt counts enabled edges since the angle became valid; the core output is
    // stable once CORE_LATENCY stages have captured, so capture on the edge after that.
    assign w_last = clk_en & (r_cnt == CNT_W'(CORE_LATENCY));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_result     <= '0;
            r_core_angle <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start && w_shortcut) begin
                        r_result <= FLOAT_ONE;
                    end else if (w_start) begin
                        r_core_angle <= dataa;
                        r_cnt        <= '0;
                    end
                end
                S_RUN: begin
                    if (!clk_en) begin
                        r_cnt <= '0;
                    end else if (w_last) begin
                        r_result <= core_result;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = w_shortcut ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Outputs: the core only runs while RUN and the CPU enable are both high,
    // since a low enable flushes the core pipeline.
    always_comb begin
        done        = 1'b0;
        core_clk_en = 1'b0;
        unique case (r_state)
            S_RUN:   core_clk_en = clk_en;
            S_DONE:  done        = 1'b1;
            default: begin
                done        = 1'b0;
                core_clk_en = 1'b0;
            end
        endcase
    end

    assign result     = r_result;
    assign core_angle = r_core_angle;

endmodule

// File: tb/tb_cosine_ci_ctrl.sv
// Self-checking bench for cosine_ci_ctrl: behavioural core stand-in, vector table,
// directed corner sequences and randomized traffic against a transaction-level model.
`timescale 1ns/1ps

module tb_cosine_ci_ctrl;

    localparam int          LAT       = 2;
    localparam int          CNT_W     = 4;
    localparam logic [31:0] MASK      = 32'h5A5A_5A5A;
    localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        core_clk_en;
    logic [31:0] core_angle;
    logic [31:0] core_result;

    int n_checks;
    int n_errors;

    cosine_ci_ctrl #(
        .CORE_LATENCY(LAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .result     (result),
        .done       (done),
        .core_clk_en(core_clk_en),
        .core_angle (core_angle),
        .core_result(core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: LAT-stage pipe that zeroes itself whenever its enable is low.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (core_clk_en) begin
            pipe[0] <= core_angle;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end else begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end
    end
    assign core_result = pipe[LAT-1] ^ MASK;

    // Transaction-level reference: one instruction in flight; it completes after
    // LAT+1 consecutive enabled edges, any disabled edge restarts the wait.
    bit          m_busy;
    bit          m_done;
    int          m_seen;
    logic [31:0] m_angle;
    logic [31:0] m_result;

    task automatic model_edge();
        if (reset) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_seen   = 0;
            m_angle  = '0;
            m_result = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            if (clk_en) begin
                m_seen++;
                if (m_seen == LAT + 1) begin
                    m_result = m_angle ^ MASK;
                    m_done   = 1'b1;
                    m_busy   = 1'b0;
                end
            end else begin
                m_seen = 0;
            end
        end else if (clk_en && start) begin
`ifdef COSINE_ZERO_SHORTCUT_EN
            if (dataa[30:0] == 31'd0) begin
                m_result = FLOAT_ONE;
                m_done   = 1'b1;
            end else begin
                m_angle = dataa;
                m_busy  = 1'b1;
                m_seen  = 0;
            end
`else
            m_angle = dataa;
            m_busy  = 1'b1;
            m_seen  = 0;
`endif
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance one edge, compare against the model.
    task automatic step(input bit rst, input bit ce, input bit st, input logic [31:0] d);
        reset  = rst;
        clk_en = ce;
        start  = st;
        dataa  = d;
        model_edge();
        @(posedge clk);
        #1;
        check("model_done", 32'(done), 32'(m_done));
        check("model_result", result, m_result);
        check("model_core_clk_en", 32'(core_clk_en), 32'(m_busy & clk_en));
        check("model_core_angle", core_angle, m_angle);
    endtask

    typedef struct {
        bit          rst;
        bit          ce;
        bit          st;
        logic [31:0] d;
        bit          e_done;
        logic [31:0] e_result;
        bit          e_cce;
        logic [31:0] e_angle;
    } vec_t;

    vec_t tbl [12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        clk_en   = 1'b0;
        start    = 1'b0;
        dataa    = '0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_seen   = 0;
        m_angle  = '0;
        m_result = '0;

        // Reset, first instruction, start during DONE, back-to-back instruction.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h3F00_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h3F00_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h3F00_0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h3F00_0000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h3F00_0000};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h655A_5A5A, 1'b0, 32'h3F00_0000};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h655A_5A5A, 1'b0, 32'h3F00_0000};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 32'h655A_5A5A, 1'b1, 32'h4000_0000};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h655A_5A5A, 1'b1, 32'h4000_0000};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h655A_5A5A, 1'b1, 32'h4000_0000};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h1A5A_5A5A, 1'b0, 32'h4000_0000};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h1A5A_5A5A, 1'b0, 32'h4000_0000};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].ce, tbl[i].st, tbl[i].d);
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            check($sformatf("tbl%0d_result", i), result, tbl[i].e_result);
            check($sformatf("tbl%0d_core_clk_en", i), 32'(core_clk_en), 32'(tbl[i].e_cce));
            check($sformatf("tbl%0d_core_angle", i), core_angle, tbl[i].e_angle);
        end

        // start while in RUN is ignored.
        step(1'b0, 1'b1, 1'b1, 32'h3E80_0000);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        check("run_start_angle", core_angle, 32'h3E80_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("run_start_done", 32'(done), 32'd1);
        check("run_start_result", result, 32'h64DA_5A5A);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // clk_en gap mid-RUN restarts the core wait.
        step(1'b0, 1'b1, 1'b1, 32'hC049_0FDB);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("gap_cce_0", 32'(core_clk_en), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("gap_cce_1", 32'(core_clk_en), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("gap_not_done_early", 32'(done), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("gap_done", 32'(done), 32'd1);
        check("gap_result", result, 32'h9A13_5581);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Reset in RUN with counter=1 aborts the instruction.
        step(1'b0, 1'b1, 1'b1, 32'h3F00_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_run_result", result, 32'h0);
        check("rst_run_cce", 32'(core_clk_en), 32'd0);
        check("rst_run_angle", core_angle, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check($sformatf("rst_run_no_done%0d", i), 32'(done), 32'd0);
        end

        // Negative-zero angle.
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000);
`ifdef COSINE_ZERO_SHORTCUT_EN
        check("zero_done", 32'(done), 32'd1);
        check("zero_result", result, FLOAT_ONE);
        check("zero_cce", 32'(core_clk_en), 32'd0);
        check("zero_angle", core_angle, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("zero_done_clear", 32'(done), 32'd0);
`else
        check("zero_cce", 32'(core_clk_en), 32'd1);
        check("zero_angle", core_angle, 32'h8000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_result", result, 32'hDA5A_5A5A);
`endif
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
            else                           d = $urandom;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
